input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage for the 3-input combinational logic block.
- Takes three raw asynchronous switch/button levels and synchronises them to `clk`, then debounces each one independently.
- Drives clean, stable `a_out`/`b_out`/`c_out` levels directly into the logic inputs A/B/C.
- Also emits per-bit edge pulses and a buffered change-event record with a valid/ready handshake, for a logger or host interface.

Parameters:
- DEB_CYCLES, 1000: consecutive cycles a synchronised level must differ from the stable level before it is accepted; legal range ≥1.
- CNT_W, 16: width of each debounce counter; requires DEB_CYCLES ≤ 2^CNT_W.
- TS_W, 32: timestamp width; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- raw_in  in  3  raw async levels; bit0→A, bit1→B, bit2→C
- a_out  out  1  debounced A, to logic block input A
- b_out  out  1  debounced B, to logic block input B
- c_out  out  1  debounced C, to logic block input C
- rise  out  3  one-cycle pulse per bit on an accepted 0→1 change
- fall  out  3  one-cycle pulse per bit on an accepted 1→0 change
- evt_valid  out  1  event record pending
- evt_ready  in  1  consumer accepts the record
- evt_data  out  3  stable vector {c,b,a} at the time of the event
- evt_ovf  out  1  sticky: an event was overwritten before acceptance
- ovf_clr  in  1  clears evt_ovf

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a rising edge) clears all of the following to 0:
  - synchroniser flops and debounce counters
  - a_out/b_out/c_out, rise, fall
  - evt_valid, evt_data, evt_ovf
- Reset asserted mid-debounce abandons the count. No pulses or events are generated by reset or by its release.

Synchroniser:
- Two flops per bit: sync1 ← raw_in, sync2 ← sync1.

Debounce, per bit i, with stable level s[i]:
- If sync2[i] == s[i]: cnt[i] ← 0.
- Else if cnt[i] == DEB_CYCLES−1: s[i] ← sync2[i] and cnt[i] ← 0.
- Else: cnt[i] ← cnt[i]+1.
- Any return of sync2 to s before acceptance restarts the count, so glitches shorter than DEB_CYCLES are ignored.

Latency:
- Number the first edge that samples a new raw level as edge 1. The output changes at edge DEB_CYCLES+2 if the level is held.
- Example: DEB_CYCLES=4 gives an output change at edge 6.

Edge pulses:
- rise[i]/fall[i] are registered and high for exactly the one cycle in which the new s[i] first appears on the output.
- Multiple bits may change on the same edge; each bit pulses independently.

Event buffer:
- Change edge = any s bit updates at that edge.
- Acceptance = evt_valid && evt_ready at an edge.
- Change edge, no pending record: evt_valid ← 1, evt_data ← new {c,b,a}.
- Acceptance without a change edge: evt_valid ← 0 next cycle.
- Acceptance and change edge together: the record is consumed and reloaded with the new vector; evt_valid stays 1; no overflow.
- Change edge while pending and not accepted: evt_data ← newest vector (overwrite), evt_ovf ← 1.
- evt_data is stable while evt_valid is high and no overwrite occurs.
- ovf_clr at an edge clears evt_ovf. If ovf_clr and an overflow happen at the same edge, set wins.
- evt_ready is ignored while evt_valid is low.

Optional Feature:
INCOND_TIMESTAMP_EN
- Defined:
  - Adds output port `evt_time` (width TS_W).
  - A free-running cycle counter resets to 0 and wraps from 2^TS_W−1 to 0.
  - evt_time captures the counter value at the same edges that load or overwrite evt_data, and holds otherwise.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (DEB_CYCLES=4):
1. Hold rst 3 cycles with raw_in=3'b111 → all outputs 0, no rise pulses after release until a full debounce completes; a_out/b_out/c_out=1 at edge 6 after release.
2. raw_in[0] high for 3 cycles then low → a_out stays 0, rise=0, evt_valid=0.
3. raw_in=3'b101 held, evt_ready=1 → at edge 6 a_out=1, c_out=1, rise=3'b101 for one cycle, evt_valid=1 with evt_data=3'b101; evt_valid drops the next cycle.
4. evt_ready=0; change to 3'b101, then after acceptance of that change to 3'b001 → evt_data=3'b001, evt_ovf=1; pulse ovf_clr → evt_ovf=0; raise evt_ready → evt_valid=0 next cycle.
5. Accept a pending record on the same edge a new change is accepted → evt_valid stays 1, evt_data holds the new vector, evt_ovf stays 0.
6. Assert rst with cnt[1]=2 mid-debounce → b_out=0, no fall/rise pulse; after release the count restarts from 0, so b_out changes only after a full DEB_CYCLES+2 edges.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronises and debounces three raw switch levels, emits per-bit edge pulses and a buffered change-event record.
// Optional feature: define INCOND_TIMESTAMP_EN to add a cycle-count timestamp (evt_time) to each event record.
module input_conditioner #(
  parameter int DEB_CYCLES = 1000,
  parameter int CNT_W      = 16
`ifdef INCOND_TIMESTAMP_EN
  ,
  parameter int TS_W       = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] raw_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic [2:0] rise,
  output logic [2:0] fall,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_data,
  output logic       evt_ovf,
  input  logic       ovf_clr
`ifdef INCOND_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0] evt_time
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       stable_q, stable_d;
  logic [2:0]       rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             evt_valid_q, evt_valid_d;
  logic [2:0]       evt_data_q, evt_data_d;
  logic             evt_ovf_q, evt_ovf_d;
  logic             change;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
        else                      cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
    change = |(stable_d ^ stable_q);
  end

  // A change that lands on an accepting edge reloads the record instead of overflowing.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    evt_ovf_d   = evt_ovf_q;
    if (ovf_clr) evt_ovf_d = 1'b0;
    if (change) begin
      evt_valid_d = 1'b1;
      evt_data_d  = stable_d;
      if (evt_valid_q && !evt_ready) evt_ovf_d = 1'b1;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the debounce counters are reset with the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

`ifdef INCOND_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d, evt_time_q, evt_time_d;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    evt_time_d = change ? ts_q : evt_time_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      evt_time_q <= '0;
    end else begin
      ts_q       <= ts_d;
      evt_time_q <= evt_time_d;
    end
  end

  assign evt_time = evt_time_q;
`endif

  assign a_out     = stable_q[0];
  assign b_out     = stable_q[1];
  assign c_out     = stable_q[2];
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEB_CYCLES=4): directed scenarios plus randomized traffic vs a behavioural model.
module tb_input_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw_in = '0;
  logic       a_out, b_out, c_out;
  logic [2:0] rise, fall;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [2:0] evt_data;
  logic       evt_ovf;
  logic       ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .a_out(a_out), .b_out(b_out), .c_out(c_out),
    .rise(rise), .fall(fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Behavioural model: a two-deep sample pipe, a run length of disagreeing samples per bit, and the record buffer.
  logic [2:0] m_pipe1 = '0, m_pipe2 = '0, m_s = '0, m_rise = '0, m_fall = '0, m_data = '0;
  logic       m_valid = 1'b0, m_ovf = 1'b0;
  int         m_run [3] = '{0, 0, 0};

  wire [13:0] dut_vec = {c_out, b_out, a_out, rise, fall, evt_valid, evt_data, evt_ovf};

  function automatic logic [13:0] exp_vec();
    return {m_s, m_rise, m_fall, m_valid, m_data, m_ovf};
  endfunction

  task automatic model_edge(input logic [2:0] r, input logic rdy, input logic clr, input logic rs);
    logic [2:0] samp, new_s;
    if (rs) begin
      m_pipe1 = '0; m_pipe2 = '0; m_s = '0; m_rise = '0; m_fall = '0;
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      return;
    end
    samp  = m_pipe2;
    new_s = m_s;
    for (int i = 0; i < 3; i++) begin
      if (samp[i] == m_s[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          new_s[i] = samp[i];
          m_run[i] = 0;
        end
      end
    end
    m_rise = new_s & ~m_s;
    m_fall = m_s & ~new_s;
    if (clr) m_ovf = 1'b0;
    if (new_s != m_s) begin
      if (m_valid && !rdy) m_ovf = 1'b1;
      m_valid = 1'b1;
      m_data  = new_s;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_s     = new_s;
    m_pipe2 = m_pipe1;
    m_pipe1 = r;
  endtask

  // Inputs change on the falling edge; outputs are observed on the following falling edge.
  task automatic step(input logic [2:0] r, input logic rdy, input logic clr, input logic rs);
    raw_in = r; evt_ready = rdy; ovf_clr = clr; rst = rs;
    @(posedge clk);
    model_edge(r, rdy, clr, rs);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(3'b111, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== 14'd0) begin
        errors++; $display("FAIL reset_hold cyc %0d got %b exp %b", cyc, dut_vec, 14'd0);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step(3'b111, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_release edge %0d got %b exp %b", k, dut_vec, exp_vec());
      end
      if (k == 5 || k == 6) begin
        checks++;
        if ({c_out, b_out, a_out} !== ((k == 6) ? 3'b111 : 3'b000)) begin
          errors++; $display("FAIL reset_latency edge %0d got %b exp %b", k, {c_out, b_out, a_out}, (k == 6) ? 3'b111 : 3'b000);
        end
      end
    end
  endtask

  task automatic test_glitch();
    step(3'b000, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step((k <= 3) ? 3'b001 : 3'b000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL glitch_model edge %0d got %b exp %b", k, dut_vec, exp_vec());
      end
      checks++;
      if ({a_out, rise[0], evt_valid} !== 3'b000) begin
        errors++; $display("FAIL glitch_ignored edge %0d got %b exp 000", k, {a_out, rise[0], evt_valid});
      end
    end
  endtask

  task automatic test_event();
    for (int k = 1; k <= 8; k++) begin
      step(3'b101, 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL event_model edge %0d got %b exp %b", k, dut_vec, exp_vec());
      end
      if (k == 6) begin
        checks++;
        if ({a_out, c_out, rise, evt_valid, evt_data} !== 9'b11_101_1_101) begin
          errors++; $display("FAIL event_fire got %b exp %b", {a_out, c_out, rise, evt_valid, evt_data}, 9'b11_101_1_101);
        end
      end
      if (k == 7) begin
        checks++;
        if ({rise, evt_valid} !== 4'b0000) begin
          errors++; $display("FAIL event_drop got %b exp 0000", {rise, evt_valid});
        end
      end
    end
  endtask

  task automatic test_overflow();
    step(3'b000, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step((k <= 6) ? 3'b101 : 3'b001, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ovf_model edge %0d got %b exp %b", k, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({evt_valid, evt_data, evt_ovf} !== 5'b1_001_1) begin
      errors++; $display("FAIL ovf_set got %b exp 10011", {evt_valid, evt_data, evt_ovf});
    end
    step(3'b001, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({evt_valid, evt_ovf} !== 2'b10 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL ovf_clear got %b exp %b", dut_vec, exp_vec());
    end
    step(3'b001, 1'b1, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL ovf_accept got %b exp %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    step(3'b000, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step((k <= 6) ? 3'b010 : 3'b110, (k == 12), 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL b2b_model edge %0d got %b exp %b", k, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({evt_valid, evt_data, evt_ovf} !== 5'b1_110_0) begin
      errors++; $display("FAIL b2b_reload got %b exp 11100", {evt_valid, evt_data, evt_ovf});
    end
    step(3'b110, 1'b1, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got %b exp 0", evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    step(3'b000, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) step(3'b010, 1'b0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({b_out, rise, fall} !== 7'd0) begin
      errors++; $display("FAIL rstmid_abandon got %b exp 0000000", {b_out, rise, fall});
    end
    for (int k = 1; k <= 7; k++) begin
      step(3'b010, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rstmid_model edge %0d got %b exp %b", k, dut_vec, exp_vec());
      end
      if (k == 5 || k == 6) begin
        checks++;
        if (b_out !== (k == 6)) begin
          errors++; $display("FAIL rstmid_restart edge %0d got %b exp %b", k, b_out, (k == 6));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] r = '0;
    logic       rdy, clr, rs;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      rdy = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      step(r, rdy, clr, rs);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %b exp %b", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_glitch();
    test_event();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
